// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl
// Description : Two-client arbiter for a single shared external ALU. Captures
//               the winning request's operands, holds them on the ALU for
//               ALU_LAT cycles, registers result and flags, and returns them
//               with a one-cycle done pulse. Ties alternate between clients.
//               Optional per-client completion counters are built when the
//               macro ALU_SHARE_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_ctrl #(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             c0,
    input  logic             c1,
    input  logic [2:0]       opc0,
    input  logic [2:0]       opc1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] rsp_w,
    output logic             rsp_z,
    output logic             rsp_n,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_c,
    output logic [2:0]       alu_opc,
    input  logic [WIDTH-1:0] alu_w,
    input  logic             alu_z,
    input  logic             alu_n,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // Latency counter is 4 bits wide because ALU_LAT is limited to 1..15.
    localparam logic [3:0] c_LAT_M1 = 4'(ALU_LAT - 1);

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    // Client of the most recent grant; also identifies the owner of the
    // operation currently in flight.
    logic       r_last_grant;
    logic       w_pick1;
    logic       w_finish;

    // Client 1 wins when it is the only requester, or on a tie when client 0
    // was served last.
    assign w_pick1  = req1 & (~req0 | ~r_last_grant);
    assign w_finish = (r_state == c_EXEC) && (r_cnt == 4'd0);
    assign busy     = (r_state != c_IDLE);

    // Arbitration, operand capture, latency timing and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            rsp_w        <= '0;
            rsp_z        <= 1'b0;
            rsp_n        <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_c        <= 1'b0;
            alu_opc      <= 3'd0;
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (req0 | req1) begin
                        if (w_pick1) begin
                            alu_a   <= a1;
                            alu_b   <= b1;
                            alu_c   <= c1;
                            alu_opc <= opc1;
                            ack1    <= 1'b1;
                        end else begin
                            alu_a   <= a0;
                            alu_b   <= b0;
                            alu_c   <= c0;
                            alu_opc <= opc0;
                            ack0    <= 1'b1;
                        end
                        r_last_grant <= w_pick1;
                        r_cnt        <= c_LAT_M1;
                        r_state      <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        rsp_w   <= alu_w;
                        rsp_z   <= alu_z;
                        rsp_n   <= alu_n;
                        done0   <= ~r_last_grant;
                        done1   <= r_last_grant;
                        r_state <= c_RESP;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SHARE_STATS_EN
    // Saturating per-client completion counters, stepped with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= 16'd0;
            cnt1 <= 16'd0;
        end else if (w_finish) begin
            if (!r_last_grant && (cnt0 != 16'hFFFF)) begin
                cnt0 <= cnt0 + 16'd1;
            end
            if (r_last_grant && (cnt1 != 16'hFFFF)) begin
                cnt1 <= cnt1 + 16'd1;
            end
        end
    end
`else
    assign cnt0 = 16'd0;
    assign cnt1 = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_ctrl
// Description : Directed self-checking bench for alu_share_ctrl. One instance
//               with ALU_LAT=1 covers arbitration, results and flags; a second
//               with ALU_LAT=3 covers latency and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst1, rst3;
    logic        req0, req1, req0_3, req1_3;
    logic [15:0] a0, b0, a1, b1;
    logic        c0, c1;
    logic [2:0]  opc0, opc1;

    logic        d1_ack0, d1_ack1, d1_done0, d1_done1, d1_rsp_z, d1_rsp_n, d1_busy, d1_alu_c;
    logic [15:0] d1_rsp_w, d1_alu_a, d1_alu_b, d1_cnt0, d1_cnt1;
    logic [2:0]  d1_alu_opc;
    logic [15:0] m1_w;
    logic        m1_z, m1_n;

    logic        d3_ack0, d3_ack1, d3_done0, d3_done1, d3_rsp_z, d3_rsp_n, d3_busy, d3_alu_c;
    logic [15:0] d3_rsp_w, d3_alu_a, d3_alu_b, d3_cnt0, d3_cnt1;
    logic [2:0]  d3_alu_opc;
    logic [15:0] m3_w;
    logic        m3_z, m3_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Reference ALU: add with carry, subtract, otherwise zero.
    function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic c, input logic [2:0] opc);
        if (opc == 3'd0) return a + b + {15'd0, c};
        if (opc == 3'd1) return a - b;
        return 16'd0;
    endfunction

    assign m1_w = alu_model(d1_alu_a, d1_alu_b, d1_alu_c, d1_alu_opc);
    assign m1_z = (m1_w == 16'd0);
    assign m1_n = m1_w[15];
    assign m3_w = alu_model(d3_alu_a, d3_alu_b, d3_alu_c, d3_alu_opc);
    assign m3_z = (m3_w == 16'd0);
    assign m3_n = m3_w[15];

    alu_share_ctrl #(.WIDTH(16), .ALU_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst1), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .c0(c0), .c1(c1), .opc0(opc0), .opc1(opc1),
        .ack0(d1_ack0), .ack1(d1_ack1), .done0(d1_done0), .done1(d1_done1),
        .rsp_w(d1_rsp_w), .rsp_z(d1_rsp_z), .rsp_n(d1_rsp_n), .busy(d1_busy),
        .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_c(d1_alu_c), .alu_opc(d1_alu_opc),
        .alu_w(m1_w), .alu_z(m1_z), .alu_n(m1_n), .cnt0(d1_cnt0), .cnt1(d1_cnt1)
    );

    alu_share_ctrl #(.WIDTH(16), .ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst3), .req0(req0_3), .req1(req1_3),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .c0(c0), .c1(c1), .opc0(opc0), .opc1(opc1),
        .ack0(d3_ack0), .ack1(d3_ack1), .done0(d3_done0), .done1(d3_done1),
        .rsp_w(d3_rsp_w), .rsp_z(d3_rsp_z), .rsp_n(d3_rsp_n), .busy(d3_busy),
        .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_c(d3_alu_c), .alu_opc(d3_alu_opc),
        .alu_w(m3_w), .alu_z(m3_z), .alu_n(m3_n), .cnt0(d3_cnt0), .cnt1(d3_cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset1();
        rst1 = 1'b1;
        tick();
        tick();
        rst1 = 1'b0;
    endtask

    // Wait for a grant on the ALU_LAT=1 instance, drop that client's request,
    // then wait for its done and check the returned result and flags.
    task automatic wait_op(input int exp_id, input logic [15:0] ew, input logic ez,
                           input logic en, input string tag);
        int k;
        int gid;
        k = 0;
        while (!(d1_ack0 || d1_ack1) && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_ack_seen"}, 32'(d1_ack0 | d1_ack1), 32'd1);
        check({tag, "_ack_excl"}, 32'(d1_ack0 & d1_ack1), 32'd0);
        gid = d1_ack1 ? 1 : 0;
        check({tag, "_grant"}, 32'(gid), 32'(exp_id));
        if (gid == 0) req0 = 1'b0;
        else          req1 = 1'b0;
        k = 0;
        while (!(d1_done0 || d1_done1) && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_done_id"}, {30'd0, d1_done1, d1_done0}, (exp_id == 0) ? 32'd1 : 32'd2);
        check({tag, "_rsp_w"}, 32'(d1_rsp_w), 32'(ew));
        check({tag, "_rsp_z"}, 32'(d1_rsp_z), 32'(ez));
        check({tag, "_rsp_n"}, 32'(d1_rsp_n), 32'(en));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        req0 = 1'b0; req1 = 1'b0; req0_3 = 1'b0; req1_3 = 1'b0;
        a0 = 16'd5; b0 = 16'd7; c0 = 1'b1; opc0 = 3'd0;
        a1 = 16'd10; b1 = 16'd4; c1 = 1'b0; opc1 = 3'd1;
        tick();
        tick();
        rst1 = 1'b0;
        rst3 = 1'b0;

        // Reset state
        check("rst_busy",  32'(d1_busy),  32'd0);
        check("rst_ack",   {30'd0, d1_ack1, d1_ack0}, 32'd0);
        check("rst_done",  {30'd0, d1_done1, d1_done0}, 32'd0);
        check("rst_rsp_w", 32'(d1_rsp_w), 32'd0);
        check("rst_alu_a", 32'(d1_alu_a), 32'd0);
        check("rst_alu_b", 32'(d1_alu_b), 32'd0);
        check("rst_cnt0",  32'(d1_cnt0),  32'd0);

        // Single request from client 0: 5 + 7 + 1 = 13
        req0 = 1'b1;
        tick();
        check("s_ack0",  32'(d1_ack0),  32'd1);
        check("s_ack1",  32'(d1_ack1),  32'd0);
        check("s_busy",  32'(d1_busy),  32'd1);
        check("s_alu_a", 32'(d1_alu_a), 32'd5);
        req0 = 1'b0;
        tick();
        check("s_ack0_w", 32'(d1_ack0),  32'd0);
        check("s_done0",  32'(d1_done0), 32'd1);
        check("s_done1",  32'(d1_done1), 32'd0);
        check("s_rsp_w",  32'(d1_rsp_w), 32'd13);
        check("s_rsp_z",  32'(d1_rsp_z), 32'd0);
        check("s_rsp_n",  32'(d1_rsp_n), 32'd0);
        tick();
        check("s_done0_w", 32'(d1_done0), 32'd0);
        check("s_idle",    32'(d1_busy),  32'd0);

        // Tie after reset: client 0 first, client 1 at next IDLE sample
        reset1();
        req0 = 1'b1;
        req1 = 1'b1;
        wait_op(0, 16'd13, 1'b0, 1'b0, "tie0");
        tick();
        tick();
        check("tie_ack1_next", 32'(d1_ack1), 32'd1);
        wait_op(1, 16'd6, 1'b0, 1'b0, "tie1");

        // Fairness: both held, re-raised after each ack
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) wait_op(0, 16'd13, 1'b0, 1'b0, "fair");
            else            wait_op(1, 16'd6, 1'b0, 1'b0, "fair");
            if (i % 2 == 0) req0 = 1'b1;
            else            req1 = 1'b1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();

        // Flags: 3 - 3 = 0 (zero), 2 - 5 = 0xFFFD (negative)
        a1 = 16'd3; b1 = 16'd3;
        req1 = 1'b1;
        wait_op(1, 16'd0, 1'b1, 1'b0, "flag_z");
        tick();
        a1 = 16'd2; b1 = 16'd5;
        req1 = 1'b1;
        wait_op(1, 16'hFFFD, 1'b0, 1'b1, "flag_n");
        tick();

        // Counters: 3 ops from client 0, 2 from client 1
        reset1();
        for (int i = 0; i < 3; i++) begin
            req0 = 1'b1;
            wait_op(0, 16'd13, 1'b0, 1'b0, "st0");
        end
        for (int i = 0; i < 2; i++) begin
            req1 = 1'b1;
            wait_op(1, 16'hFFFD, 1'b0, 1'b1, "st1");
        end
        tick();
`ifdef ALU_SHARE_STATS_EN
        check("cnt0", 32'(d1_cnt0), 32'd3);
        check("cnt1", 32'(d1_cnt1), 32'd2);
`else
        check("cnt0", 32'(d1_cnt0), 32'd0);
        check("cnt1", 32'(d1_cnt1), 32'd0);
`endif
        reset1();
        check("cnt0_rst", 32'(d1_cnt0), 32'd0);
        check("cnt1_rst", 32'(d1_cnt1), 32'd0);

        // ALU_LAT=3: done four cycles after the sampling edge
        req0_3 = 1'b1;
        tick();
        check("l3_ack0", 32'(d3_ack0), 32'd1);
        req0_3 = 1'b0;
        tick();
        check("l3_done_c2", 32'(d3_done0), 32'd0);
        tick();
        check("l3_done_c3", 32'(d3_done0), 32'd0);
        tick();
        check("l3_done_c4", 32'(d3_done0), 32'd1);
        check("l3_rsp_w",   32'(d3_rsp_w), 32'd13);
        tick();
        check("l3_idle", 32'(d3_busy), 32'd0);

        // Reset during second EXEC cycle: no done, outputs cleared
        req0_3 = 1'b1;
        tick();
        check("l3r_ack0", 32'(d3_ack0), 32'd1);
        req0_3 = 1'b0;
        tick();
        rst3 = 1'b1;
        tick();
        check("l3r_busy",  32'(d3_busy),  32'd0);
        check("l3r_done",  {30'd0, d3_done1, d3_done0}, 32'd0);
        check("l3r_ack",   {30'd0, d3_ack1, d3_ack0}, 32'd0);
        check("l3r_alu_a", 32'(d3_alu_a), 32'd0);
        check("l3r_rsp_w", 32'(d3_rsp_w), 32'd0);
        rst3 = 1'b0;
        req0_3 = 1'b1;
        req1_3 = 1'b1;
        tick();
        check("l3r_tie_ack0", 32'(d3_ack0), 32'd1);
        check("l3r_tie_ack1", 32'(d3_ack1), 32'd0);
        req0_3 = 1'b0;
        req1_3 = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Arbitrates one shared 16-bit ALU (operands a, b, carry-in c, 3-bit opcode; outputs w, zero flag, negative flag) between two requesters.
- Captures the winning request's operands and drives the ALU for a fixed number of cycles. Registers the result and flags, then returns them with a done pulse.
- Sits between two datapath clients and the single ALU instance; the ALU itself is external.

Parameters:
- WIDTH, 16, operand/result width.
- ALU_LAT, 1, cycles ALU inputs are held before w/z/n are sampled; legal range 1..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1  request from client 0/1; held high with operands stable until matching ack.
- a0, b0, a1, b1  in  WIDTH  operands of client 0/1.
- c0, c1  in  1  carry-in of client 0/1.
- opc0, opc1  in  3  opcode of client 0/1.
- ack0, ack1  out  1  one-cycle pulse: request captured.
- done0, done1  out  1  one-cycle pulse: rsp_* valid for that client.
- rsp_w  out  WIDTH  registered ALU result.
- rsp_z, rsp_n  out  1  registered zero/negative flags.
- busy  out  1  high whenever state != IDLE.
- alu_a, alu_b  out  WIDTH  to ALU.
- alu_c  out  1  to ALU.
- alu_opc  out  3  to ALU.
- alu_w  in  WIDTH  from ALU.
- alu_z, alu_n  in  1  from ALU.
- cnt0, cnt1  out  16  operation counters (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, last_grant=1 (client 0 wins first tie).
  - All outputs 0, including alu_* and rsp_*; latency counter 0.
  - Any in-flight operation is dropped; no done is issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - At an edge with req0|req1 high, pick the winner.
  - Only one requesting: that client wins.
  - Both requesting: the client != last_grant wins.
  - Latch the winner's a/b/c/opc into alu_a/alu_b/alu_c/alu_opc.
  - Update last_grant; set ackN=1 for the next cycle; load cnt=ALU_LAT-1; go to EXEC.
  - No request: stay in IDLE.
- EXEC:
  - alu_* held constant.
  - cnt!=0: decrement.
  - cnt==0: at that edge capture alu_w/alu_z/alu_n into rsp_w/rsp_z/rsp_n, set doneN=1 for the next cycle, go to RESP.
  - EXEC lasts exactly ALU_LAT cycles.
- RESP: lasts one cycle, with doneN=1 and rsp_* valid; then go to IDLE.
- Pulse widths: ack and done are each exactly 1 cycle. Only the granted client's ack/done ever assert.
- Latency: req sampled at edge E → ack high in cycle E+1 → done high in cycle E+ALU_LAT+1.
- Throughput: one operation per ALU_LAT+2 cycles.
- rsp_* hold their value until the next capture; they are valid only while done is high.
- alu_* hold their last operands after RESP until the next grant; they are not cleared.
- Requesters must drop req in the cycle ack is seen (or later, to re-request). The FSM does not sample req outside IDLE, so requests arriving while busy simply wait.
- Simultaneous requests arriving back-to-back strictly alternate; there is no starvation.
- rst asserted during EXEC or RESP: the next cycle is IDLE with all outputs 0 and no done.

Optional Feature:
- Macro: ALU_SHARE_STATS_EN.
- Defined:
  - cnt0/cnt1 count completed operations per client, incrementing at the edge that sets doneN.
  - 16-bit saturating at 16'hFFFF; cleared by rst.
- Undefined: cnt0/cnt1 are tied to 0 and no counter logic is synthesized.

Test Plan:
- The bench's ALU model returns w=a+b+c for opc=0 and w=a-b for opc=1, with z=(w==0) and n=w[15]; ALU_LAT=1.
- Single request: req0 with a0=16'd5, b0=16'd7, c0=1, opc0=0 → ack0 one cycle after the sampling edge; done0 two cycles after it with rsp_w=16'd13, z=0, n=0; ack1/done1 stay 0.
- Tie after reset: req0 and req1 raised in the same cycle → client 0 granted first. Client 1 is acked in the first IDLE sampling after done0. Results match each client's own operands.
- Fairness: both clients hold req high continuously (re-raising after each ack), 6 operations → grant order 0,1,0,1,0,1.
- Flags: opc1=1, a1=16'd3, b1=16'd3 → rsp_w=0, z=1. Then a1=16'd2, b1=16'd5 → rsp_w=16'hFFFD, n=1, z=0.
- Latency/reset: with ALU_LAT=3, done arrives 4 cycles after the sampling edge. rst asserted during the second EXEC cycle → no done, all outputs 0 next cycle, and the following tie grants client 0.
- With ALU_SHARE_STATS_EN defined: 3 operations from client 0 and 2 from client 1 → cnt0=3, cnt1=2. rst → both 0.
